// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters for same-cycle fetch
// prediction, execute-stage branch/jump resolution, registered redirect and statistics.
module branch_predict_unit #(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic [15:0] ex_immediate,
  input  logic [25:0] ex_jump_address,
  input  logic [2:0]  ex_branch_control,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_is_jr,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_next_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int TAG_W = 32 - IDX_BITS - 2;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic             uncond_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;
  logic [31:0] branch_count_r;
  logic [31:0] mispredict_count_r;

  logic [IDX_BITS-1:0] f_idx_s, e_idx_s;
  logic                f_hit_s, e_hit_s;
  logic [1:0]          f_ctr_s, e_ctr_s;
  logic                cond_s, taken_s, mispredict_s, is_ctrl_s;
  logic [31:0]         seq_pc_s, br_target_s, jmp_target_s, actual_next_s;
  logic                unused_s;

  // The fetch-side prediction flag is carried only for debug; the redirect decision uses the PC.
  assign unused_s = ex_pred_taken;

  assign f_idx_s      = fetch_pc[IDX_BITS+1:2];
  assign f_ctr_s      = ctr_r[f_idx_s];
  assign f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == fetch_pc[31:IDX_BITS+2]);
  assign pred_taken   = f_hit_s && (uncond_r[f_idx_s] || f_ctr_s[1]);
  assign pred_next_pc = pred_taken ? target_r[f_idx_s] : (fetch_pc + 32'd4);

  assign e_idx_s      = ex_pc[IDX_BITS+1:2];
  assign e_ctr_s      = ctr_r[e_idx_s];
  assign e_hit_s      = valid_r[e_idx_s] && (tag_r[e_idx_s] == ex_pc[31:IDX_BITS+2]);
  assign seq_pc_s     = ex_pc + 32'd4;
  assign br_target_s  = seq_pc_s + {{14{ex_immediate[15]}}, ex_immediate, 2'b00};
  assign jmp_target_s = {ex_pc[31:28], ex_jump_address, 2'b00};
  assign is_ctrl_s    = ex_is_branch || ex_is_jump || ex_is_jr;

  // Compare select for conditional branches.
  always_comb begin
    cond_s = 1'b0;
    case (ex_branch_control)
      3'b000:  cond_s = (ex_rs_val == ex_rt_val);
      3'b001:  cond_s = (ex_rs_val != ex_rt_val);
      3'b010:  cond_s = ($signed(ex_rs_val) >  $signed(ex_rt_val));
      3'b011:  cond_s = ($signed(ex_rs_val) >= $signed(ex_rt_val));
      3'b100:  cond_s = ($signed(ex_rs_val) <  $signed(ex_rt_val));
      3'b101:  cond_s = ($signed(ex_rs_val) <= $signed(ex_rt_val));
      3'b110:  cond_s = (ex_rs_val <  ex_rt_val);
      3'b111:  cond_s = (ex_rs_val >  ex_rt_val);
      default: cond_s = 1'b0;
    endcase
  end

  // Actual next PC with branch > jump > jr priority.
  always_comb begin
    taken_s       = 1'b0;
    actual_next_s = seq_pc_s;
    if (ex_is_branch) begin
      taken_s       = cond_s;
      actual_next_s = cond_s ? br_target_s : seq_pc_s;
    end else if (ex_is_jump) begin
      actual_next_s = jmp_target_s;
    end else if (ex_is_jr) begin
      actual_next_s = ex_rs_val;
    end else begin
      actual_next_s = seq_pc_s;
    end
  end

  assign mispredict_s = ex_valid && (actual_next_s != ex_pred_next_pc);

  // BTB update from execute; fetch reads the pre-update contents in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        uncond_r[i] <= 1'b0;
        ctr_r[i]    <= 2'd1;
      end
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        if (e_hit_s) begin
          if (taken_s) begin
            target_r[e_idx_s] <= br_target_s;
            if (e_ctr_s != 2'd3) ctr_r[e_idx_s] <= e_ctr_s + 2'd1;
          end else if (e_ctr_s != 2'd0) begin
            ctr_r[e_idx_s] <= e_ctr_s - 2'd1;
          end
        end else if (taken_s) begin
          valid_r[e_idx_s]  <= 1'b1;
          tag_r[e_idx_s]    <= ex_pc[31:IDX_BITS+2];
          target_r[e_idx_s] <= br_target_s;
          uncond_r[e_idx_s] <= 1'b0;
          ctr_r[e_idx_s]    <= 2'd2;
        end
      end else if (ex_is_jump) begin
        valid_r[e_idx_s]  <= 1'b1;
        tag_r[e_idx_s]    <= ex_pc[31:IDX_BITS+2];
        target_r[e_idx_s] <= jmp_target_s;
        uncond_r[e_idx_s] <= 1'b1;
      end else if (e_hit_s) begin
        valid_r[e_idx_s] <= 1'b0;
      end
    end
  end

  // Registered redirect and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= 32'd0;
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      redirect_valid_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_pc_r <= actual_next_s;
        if (mispredict_count_r != 32'hFFFF_FFFF) mispredict_count_r <= mispredict_count_r + 32'd1;
      end
      if (ex_valid && is_ctrl_s && (branch_count_r != 32'hFFFF_FFFF)) begin
        branch_count_r <= branch_count_r + 32'd1;
      end
    end
  end

  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (ENTRIES=16).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_val, ex_rt_val;
  logic [15:0] ex_immediate;
  logic [25:0] ex_jump_address;
  logic [2:0]  ex_branch_control;
  logic        ex_is_branch, ex_is_jump, ex_is_jr, ex_pred_taken;
  logic [31:0] ex_pred_next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int checks = 0;
  int failures = 0;

  branch_predict_unit #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_immediate(ex_immediate), .ex_jump_address(ex_jump_address),
    .ex_branch_control(ex_branch_control), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_is_jr(ex_is_jr), .ex_pred_taken(ex_pred_taken),
    .ex_pred_next_pc(ex_pred_next_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_pc = 32'd0; ex_rs_val = 32'd0; ex_rt_val = 32'd0;
    ex_immediate = 16'd0; ex_jump_address = 26'd0; ex_branch_control = 3'd0;
    ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_is_jr = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_next_pc = 32'd0;
  endtask

  task automatic ex_step(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [25:0] ja, input logic [2:0] bc,
                         input logic br, input logic j, input logic jr, input logic [31:0] pnpc);
    ex_valid = 1'b1; ex_pc = pc; ex_rs_val = rs; ex_rt_val = rt;
    ex_immediate = imm; ex_jump_address = ja; ex_branch_control = bc;
    ex_is_branch = br; ex_is_jump = j; ex_is_jr = jr;
    ex_pred_next_pc = pnpc; ex_pred_taken = (pnpc != pc + 32'd4);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = 32'h40;
    idle();
    tick();
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_next", pred_next_pc, 32'h44);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mcount", mispredict_count, 32'd0);
    chk("rst_bcount", branch_count, 32'd0);
    rst_n = 1'b1;

    // cold beq at 0x40, taken to 0x50
    ex_step(32'h40, 32'd5, 32'd5, 16'h0003, 26'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h44);
    chk("cold_rbw", {31'd0, pred_taken}, 32'd0);
    tick();
    chk("cold_rv", {31'd0, redirect_valid}, 32'd1);
    chk("cold_rpc", redirect_pc, 32'h50);
    chk("cold_mcount", mispredict_count, 32'd1);
    chk("cold_bcount", branch_count, 32'd1);
    idle(); #1;
    chk("cold_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("cold_pred_next", pred_next_pc, 32'h50);
    tick();
    chk("pulse_rv", {31'd0, redirect_valid}, 32'd0);
    chk("hold_rpc", redirect_pc, 32'h50);

    // train taken four times back to back
    for (int i = 0; i < 4; i++) begin
      ex_step(32'h40, 32'd5, 32'd5, 16'h0003, 26'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h50);
      tick();
      chk("train_rv", {31'd0, redirect_valid}, 32'd0);
      chk("train_pred", {31'd0, pred_taken}, 32'd1);
    end
    chk("train_bcount", branch_count, 32'd5);
    chk("train_mcount", mispredict_count, 32'd1);

    // first not-taken: ctr 3->2, still predicted taken
    ex_step(32'h40, 32'd5, 32'd6, 16'h0003, 26'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h50);
    tick();
    chk("nt1_rv", {31'd0, redirect_valid}, 32'd1);
    chk("nt1_rpc", redirect_pc, 32'h44);
    chk("nt1_pred", {31'd0, pred_taken}, 32'd1);

    // alias non-control at 0x80 carrying stale prediction
    ex_step(32'h80, 32'd0, 32'd0, 16'd0, 26'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h50);
    tick();
    chk("alias_rv", {31'd0, redirect_valid}, 32'd1);
    chk("alias_rpc", redirect_pc, 32'h84);
    chk("alias_keep_pred", {31'd0, pred_taken}, 32'd1);
    chk("alias_keep_next", pred_next_pc, 32'h50);
    chk("alias_bcount", branch_count, 32'd6);

    // second not-taken: ctr 2->1, now predicted not taken
    ex_step(32'h40, 32'd5, 32'd6, 16'h0003, 26'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h50);
    tick();
    chk("nt2_pred", {31'd0, pred_taken}, 32'd0);
    chk("nt2_next", pred_next_pc, 32'h44);
    chk("nt2_mcount", mispredict_count, 32'd4);
    chk("nt2_bcount", branch_count, 32'd7);

    // retrain once (ctr 1->2), then a stale non-control at 0x40 invalidates it
    ex_step(32'h40, 32'd5, 32'd5, 16'h0003, 26'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h44);
    tick();
    chk("retrain_pred", {31'd0, pred_taken}, 32'd1);
    chk("retrain_rpc", redirect_pc, 32'h50);
    ex_step(32'h40, 32'd0, 32'd0, 16'd0, 26'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h50);
    chk("stale_rbw", {31'd0, pred_taken}, 32'd1);
    tick();
    chk("stale_rv", {31'd0, redirect_valid}, 32'd1);
    chk("stale_rpc", redirect_pc, 32'h44);
    chk("stale_inval_pred", {31'd0, pred_taken}, 32'd0);
    chk("stale_inval_next", pred_next_pc, 32'h44);
    chk("stale_mcount", mispredict_count, 32'd6);
    chk("stale_bcount", branch_count, 32'd8);

    // compare modes with rs=-1, rt=1 at 0x204 (taken target 0x214)
    fetch_pc = 32'h204;
    ex_step(32'h204, 32'hFFFF_FFFF, 32'd1, 16'h0003, 26'd0, 3'b110, 1'b1, 1'b0, 1'b0, 32'h208);
    tick();
    chk("cmp110_rv", {31'd0, redirect_valid}, 32'd0);
    ex_step(32'h204, 32'hFFFF_FFFF, 32'd1, 16'h0003, 26'd0, 3'b010, 1'b1, 1'b0, 1'b0, 32'h208);
    tick();
    chk("cmp010_rv", {31'd0, redirect_valid}, 32'd0);
    ex_step(32'h204, 32'hFFFF_FFFF, 32'd1, 16'h0003, 26'd0, 3'b100, 1'b1, 1'b0, 1'b0, 32'h208);
    tick();
    chk("cmp100_rv", {31'd0, redirect_valid}, 32'd1);
    chk("cmp100_rpc", redirect_pc, 32'h214);
    ex_step(32'h204, 32'hFFFF_FFFF, 32'd1, 16'h0003, 26'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h208);
    tick();
    chk("cmp111_rv", {31'd0, redirect_valid}, 32'd1);
    chk("cmp111_rpc", redirect_pc, 32'h214);
    chk("cmp_pred", {31'd0, pred_taken}, 32'd1);
    chk("cmp_mcount", mispredict_count, 32'd8);
    chk("cmp_bcount", branch_count, 32'd12);

    // asynchronous reset in the middle of a redirect pulse
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rv", {31'd0, redirect_valid}, 32'd0);
    chk("async_rpc", redirect_pc, 32'd0);
    chk("async_mcount", mispredict_count, 32'd0);
    chk("async_bcount", branch_count, 32'd0);
    chk("async_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    rst_n = 1'b1;

    // cold j, then jr at the same PC invalidates the entry
    fetch_pc = 32'h1000_0100;
    ex_step(32'h1000_0100, 32'd0, 32'd0, 16'd0, 26'h0000080, 3'b000, 1'b0, 1'b1, 1'b0, 32'h1000_0104);
    chk("j_cold_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    chk("j_rv", {31'd0, redirect_valid}, 32'd1);
    chk("j_rpc", redirect_pc, 32'h1000_0200);
    chk("j_pred", {31'd0, pred_taken}, 32'd1);
    chk("j_pred_next", pred_next_pc, 32'h1000_0200);
    ex_step(32'h1000_0100, 32'h300, 32'd0, 16'd0, 26'd0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h1000_0200);
    tick();
    chk("jr_rpc", redirect_pc, 32'h300);
    chk("jr_inval_pred", {31'd0, pred_taken}, 32'd0);
    chk("jr_next", pred_next_pc, 32'h1000_0104);
    chk("jr_bcount", branch_count, 32'd2);
    idle();
    tick();
    chk("idle_rv", {31'd0, redirect_valid}, 32'd0);
    chk("idle_bcount", branch_count, 32'd2);

    // mispredict counter saturation
    force dut.mispredict_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_count_r;
    ex_step(32'h500, 32'd0, 32'd0, 16'd0, 26'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("sat_mcount", mispredict_count, 32'hFFFF_FFFF);
    chk("sat_rpc", redirect_pc, 32'h504);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch resolver. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, which gives the fetch stage a same-cycle next-PC prediction. In execute it resolves branches and jumps using the same compare encodings, detects mispredictions and issues a registered redirect. It sits between the PC register, fetch and the execute stage, and also keeps branch and mispredict statistics.

## Interface
Parameters:
- ENTRIES, 16: BTB depth; power of two, range 2..256.
- IDX_BITS, $clog2(ENTRIES): BTB index width, derived.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_pc  input  32  PC being fetched.
- pred_taken  output  1  combinational prediction for fetch_pc.
- pred_next_pc  output  32  pred_taken ? BTB target : fetch_pc+4.
- ex_valid  input  1  execute-stage instruction is valid.
- ex_pc  input  32  PC of the execute instruction.
- ex_rs_val, ex_rt_val  input  32  operand values.
- ex_immediate  input  16  branch offset, in words.
- ex_jump_address  input  26  j/jal target field.
- ex_branch_control  input  3  compare select (see Operation).
- ex_is_branch, ex_is_jump, ex_is_jr  input  1  instruction class.
- ex_pred_taken  input  1  prediction piped from fetch.
- ex_pred_next_pc  input  32  prediction piped from fetch.
- redirect_valid  output  1  registered mispredict flush/redirect.
- redirect_pc  output  32  registered correct next PC.
- branch_count  output  32  resolved control-flow instructions; saturates at 0xFFFF_FFFF.
- mispredict_count  output  32  mispredictions; saturates at 0xFFFF_FFFF.

## Operation
- Entry fields: valid, tag = pc[31:IDX_BITS+2], target[31:0], uncond, ctr[1:0]. Index = pc[IDX_BITS+1:2].
- Fetch lookup:
  - hit = valid && tag match.
  - pred_taken = hit && (uncond || ctr[1]).
- Condition select for ex_branch_control:
  - 000 rs==rt
  - 001 rs!=rt
  - 010 signed rs>rt
  - 011 signed rs>=rt
  - 100 signed rs<rt
  - 101 signed rs<=rt
  - 110 unsigned rs<rt
  - 111 unsigned rs>rt
- Actual next PC, priority branch > jump > jr:
  - ex_is_branch and condition true: ex_pc+4+sext(imm)<<2.
  - ex_is_jump: {ex_pc[31:28], jump_address, 2'b00}.
  - ex_is_jr: rs_val.
  - otherwise: ex_pc+4.
- Mispredict: ex_valid && actual_next != ex_pred_next_pc. This also covers a non-control instruction that carried a stale taken prediction.
- Table update, only when ex_valid (the table is re-read at ex_pc):
  - Conditional branch, hit: ctr increments (taken) or decrements (not taken), saturating at 3/0; target rewritten when taken.
  - Conditional branch, miss and taken: allocate with ctr=2, uncond=0.
  - Conditional branch, miss and not taken: no change.
  - j/jal: allocate or overwrite with uncond=1, target.
  - jr, or non-control instruction, on hit: invalidate the entry. jr is never allocated.
- branch_count increments when ex_valid and any class bit is set. mispredict_count increments on mispredict.

## Timing
- Reset, asynchronous: all valid=0, ctr=1, target=0, tag=0, uncond=0, redirect_valid=0, redirect_pc=0, both counts=0. Outputs take these values immediately on rst_n falling, including mid-redirect.
- Prediction path is combinational, zero latency.
- Resolution latency is 1 cycle. redirect_valid and redirect_pc are registered from the execute-cycle inputs and pulse for exactly one cycle per mispredict. redirect_valid is 0 on every cycle without a mispredict; redirect_pc holds its last value.
- Fetch lookup and execute update in the same cycle to the same index are read-before-write: fetch sees the pre-update entry, and the update is visible from the next cycle.
- Back-to-back ex_valid cycles are each handled independently with no stall.
- Counters stick at 0xFFFF_FFFF once reached.
- ex_valid=0: no state change except redirect_valid going to 0.

## Test plan
- Cold beq at ex_pc=0x40, rs=rt=5, imm=0x0003, pred not-taken:
  - next cycle redirect_valid=1, redirect_pc=0x50, mispredict_count=1, branch_count=1.
  - fetch_pc=0x40 then gives pred_taken=1, pred_next_pc=0x50.
- Training: 4 taken resolutions of the same branch, then 1 not-taken:
  - pred_taken stays 1.
  - a second not-taken gives pred_taken=0.
  - ctr never exceeds 3.
- j at ex_pc=0x1000_0100, jump_address=0x0000080, cold:
  - redirect_pc=0x1000_0200.
  - fetch 0x1000_0100 then predicts 0x1000_0200 regardless of ctr.
- Alias with ENTRIES=16: allocate branch at 0x40, then execute a non-control instruction at 0x80 (same index, different tag) carrying pred_next_pc=0x50:
  - redirect_pc=0x84.
  - entry 0 stays valid, since the tag mismatches and the table is re-read.
  - a stale-prediction case at 0x40 itself invalidates entry 0.
- Compare modes, rs=0xFFFF_FFFF, rt=1:
  - control 110 gives not taken.
  - control 100 gives taken.
  - control 111 gives taken.
  - control 010 gives not taken.
- Reset and saturation:
  - drop rst_n while redirect_valid=1: redirect_valid, both counts and pred_taken go to 0 without a clock edge.
  - with mispredict_count forced to 0xFFFF_FFFF, a further mispredict holds it at 0xFFFF_FFFF.
